// File: rtl/mem_rd_arbiter.sv
// Round-robin read arbiter for the single read port of the main-memory BRAM.
// A tag pipeline follows each issued read so that the returning word reaches the requester that issued it.
module mem_rd_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned PROC_BITS  = 2,
  parameter int unsigned ADDR_WIDTH = 14,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LATENCY    = 2
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*32-1:0]   req_addr,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic                    hold_in,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic                    mem_addr_valid,
  input  logic [DATA_WIDTH-1:0]   mem_data,
  output logic [NUM_REQ-1:0]      resp_valid,
  output logic [PROC_BITS-1:0]    resp_id,
  output logic [DATA_WIDTH-1:0]   resp_data,
  output logic                    busy,
  output logic [15:0]             issue_count
);

  logic [PROC_BITS-1:0]           rr_ptr_q, rr_ptr_d;
  logic [15:0]                    issue_count_q, issue_count_d;
  logic [LATENCY-1:0]             tag_vld_q, tag_vld_d;
  logic [LATENCY*PROC_BITS-1:0]   tag_id_q, tag_id_d;

  logic                           grant_vld;
  logic [PROC_BITS-1:0]           grant_id;
  int unsigned                    grant_idx;
  int unsigned                    cand;
  int unsigned                    nxt;

  logic                           last_vld;
  logic [PROC_BITS-1:0]           last_id;
  logic                           resp_live;

  // Search upward from rr_ptr, wrapping modulo NUM_REQ; first valid requester wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = 0;
    cand      = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = 32'(rr_ptr_q) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!grant_vld && |(req_valid & (NUM_REQ'(1) << cand))) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
    if (hold_in || rst_in) begin
      grant_vld = 1'b0;
      grant_idx = 0;
    end
    grant_id = PROC_BITS'(grant_idx);
  end

  always_comb begin
    req_ready      = grant_vld ? (NUM_REQ'(1) << grant_idx) : '0;
    mem_addr_valid = grant_vld;
    mem_addr       = grant_vld ? ADDR_WIDTH'(req_addr >> (32 * grant_idx)) : '0;
  end

  always_comb begin
    nxt = grant_idx + 1;
    if (nxt >= NUM_REQ) nxt = 0;
    rr_ptr_d      = grant_vld ? PROC_BITS'(nxt) : rr_ptr_q;
    issue_count_d = grant_vld ? issue_count_q + 16'd1 : issue_count_q;
    // Shift in the new {valid, id} at stage 0; the oldest stage falls off the top.
    tag_vld_d     = LATENCY'({tag_vld_q, grant_vld});
    tag_id_d      = (LATENCY*PROC_BITS)'({tag_id_q, grant_id});
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rr_ptr_q      <= '0;
      issue_count_q <= '0;
      tag_vld_q     <= '0;
      tag_id_q      <= '0;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      issue_count_q <= issue_count_d;
      tag_vld_q     <= tag_vld_d;
      tag_id_q      <= tag_id_d;
    end
  end

  // A read whose data lands during the reset cycle is dropped along with the rest of the pipeline.
  always_comb begin
    last_vld    = tag_vld_q[LATENCY-1];
    last_id     = tag_id_q[LATENCY*PROC_BITS-1 -: PROC_BITS];
    resp_live   = last_vld && !rst_in;
    resp_valid  = resp_live ? (NUM_REQ'(1) << last_id) : '0;
    resp_id     = resp_live ? last_id : '0;
    resp_data   = mem_data;
    busy        = (|tag_vld_q) || grant_vld;
    issue_count = issue_count_q;
  end

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Directed bench for mem_rd_arbiter: a per-cycle vector table plus hand-written reset and counter-wrap sequences.
// The BRAM model returns (addr ^ 0xA5A5_0000) two cycles after the address is presented.
module tb_mem_rd_arbiter;

  localparam int unsigned NR = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req_valid;
  logic [NR*32-1:0] req_addr;
  logic [NR-1:0]   req_ready;
  logic            hold;
  logic [13:0]     mem_addr;
  logic            mem_addr_valid;
  logic [31:0]     mem_data;
  logic [NR-1:0]   resp_valid;
  logic [1:0]      resp_id;
  logic [31:0]     resp_data;
  logic            busy;
  logic [15:0]     issue_count;

  int n_vec = 0;
  int n_err = 0;

  mem_rd_arbiter #(
    .NUM_REQ(4), .PROC_BITS(2), .ADDR_WIDTH(14), .DATA_WIDTH(32), .LATENCY(2)
  ) dut (
    .clk_in(clk), .rst_in(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .hold_in(hold), .mem_addr(mem_addr),
    .mem_addr_valid(mem_addr_valid), .mem_data(mem_data), .resp_valid(resp_valid),
    .resp_id(resp_id), .resp_data(resp_data), .busy(busy), .issue_count(issue_count)
  );

  always #5 clk = ~clk;

  logic [13:0] bram_a1;
  always @(posedge clk) begin
    bram_a1  <= mem_addr;
    mem_data <= {18'd0, bram_a1} ^ 32'hA5A5_0000;
  end

  typedef struct {
    logic [3:0]  vld;
    logic        hold;
    logic [3:0]  rdy;
    logic [3:0]  rv;
    logic [1:0]  rid;
    logic        busy;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[32];

  function automatic vec_t mk(input logic [3:0] v, input logic h, input logic [3:0] r,
                              input logic [3:0] rv, input logic [1:0] id, input logic b,
                              input logic [15:0] c);
    vec_t t;
    t.vld = v; t.hold = h; t.rdy = r; t.rv = rv; t.rid = id; t.busy = b; t.cnt = c;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] exp_ma;
    string       tag;

    rst = 1'b1; hold = 1'b0; req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) req_addr[32*i +: 32] = 32'hABCD_C100 + 32'(i);

    tbl[0]  = mk(4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 0);
    tbl[1]  = mk(4'b0100, 0, 4'b0100, 4'b0000, 0, 1, 0);
    tbl[2]  = mk(4'b0000, 0, 4'b0000, 4'b0000, 0, 1, 1);
    tbl[3]  = mk(4'b0000, 0, 4'b0000, 4'b0100, 2, 1, 1);
    tbl[4]  = mk(4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 1);
    tbl[5]  = mk(4'b1111, 0, 4'b1000, 4'b0000, 0, 1, 1);
    tbl[6]  = mk(4'b1111, 0, 4'b0001, 4'b0000, 0, 1, 2);
    tbl[7]  = mk(4'b1111, 0, 4'b0010, 4'b1000, 3, 1, 3);
    tbl[8]  = mk(4'b1111, 0, 4'b0100, 4'b0001, 0, 1, 4);
    tbl[9]  = mk(4'b1111, 0, 4'b1000, 4'b0010, 1, 1, 5);
    tbl[10] = mk(4'b1111, 0, 4'b0001, 4'b0100, 2, 1, 6);
    tbl[11] = mk(4'b1111, 0, 4'b0010, 4'b1000, 3, 1, 7);
    tbl[12] = mk(4'b1111, 0, 4'b0100, 4'b0001, 0, 1, 8);
    tbl[13] = mk(4'b0000, 0, 4'b0000, 4'b0010, 1, 1, 9);
    tbl[14] = mk(4'b0000, 0, 4'b0000, 4'b0100, 2, 1, 9);
    tbl[15] = mk(4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 9);
    tbl[16] = mk(4'b1111, 0, 4'b1000, 4'b0000, 0, 1, 9);
    tbl[17] = mk(4'b1111, 0, 4'b0001, 4'b0000, 0, 1, 10);
    tbl[18] = mk(4'b1111, 1, 4'b0000, 4'b1000, 3, 1, 11);
    tbl[19] = mk(4'b1111, 1, 4'b0000, 4'b0001, 0, 1, 11);
    tbl[20] = mk(4'b1111, 1, 4'b0000, 4'b0000, 0, 0, 11);
    tbl[21] = mk(4'b1111, 0, 4'b0010, 4'b0000, 0, 1, 11);
    tbl[22] = mk(4'b1111, 0, 4'b0100, 4'b0000, 0, 1, 12);
    tbl[23] = mk(4'b0000, 0, 4'b0000, 4'b0010, 1, 1, 13);
    tbl[24] = mk(4'b0000, 0, 4'b0000, 4'b0100, 2, 1, 13);
    tbl[25] = mk(4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 13);
    tbl[26] = mk(4'b0010, 0, 4'b0010, 4'b0000, 0, 1, 13);
    tbl[27] = mk(4'b1010, 0, 4'b1000, 4'b0000, 0, 1, 14);
    tbl[28] = mk(4'b0010, 0, 4'b0010, 4'b0010, 1, 1, 15);
    tbl[29] = mk(4'b0000, 0, 4'b0000, 4'b1000, 3, 1, 16);
    tbl[30] = mk(4'b0000, 0, 4'b0000, 4'b0010, 1, 1, 16);
    tbl[31] = mk(4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 16);

    // Reset state, with every requester asserting so that a leaked grant would show.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.ready",      32'(req_ready),      32'h0);
    chk("rst.maddr_v",    32'(mem_addr_valid), 32'h0);
    chk("rst.resp_valid", 32'(resp_valid),     32'h0);
    chk("rst.resp_id",    32'(resp_id),        32'h0);
    chk("rst.busy",       32'(busy),           32'h0);
    chk("rst.count",      32'(issue_count),    32'h0);
    next_cycle();
    rst = 1'b0;

    for (int i = 0; i < 32; i++) begin
      req_valid = tbl[i].vld;
      hold      = tbl[i].hold;
      @(negedge clk);
      exp_ma = 32'h0;
      for (int g = 0; g < 4; g++)
        if (tbl[i].rdy[g]) exp_ma = 32'h100 + 32'(g);
      tag = $sformatf("row%0d", i);
      chk({tag, ".ready"},      32'(req_ready),      32'(tbl[i].rdy));
      chk({tag, ".maddr_v"},    32'(mem_addr_valid), 32'(|tbl[i].rdy));
      chk({tag, ".maddr"},      32'(mem_addr),       exp_ma);
      chk({tag, ".resp_valid"}, 32'(resp_valid),     32'(tbl[i].rv));
      chk({tag, ".resp_id"},    32'(resp_id),        32'(tbl[i].rid));
      chk({tag, ".busy"},       32'(busy),           32'(tbl[i].busy));
      chk({tag, ".count"},      32'(issue_count),    32'(tbl[i].cnt));
      if (tbl[i].rv != 4'b0000)
        chk({tag, ".resp_data"}, resp_data, (32'h100 + 32'(tbl[i].rid)) ^ 32'hA5A5_0000);
      next_cycle();
    end

    // Reset while two reads are in flight: neither may respond, and the pointer restarts at 0.
    req_valid = 4'b0001;
    @(negedge clk); chk("rmf.grantA", 32'(req_ready), 32'h1);
    next_cycle();
    req_valid = 4'b0010;
    @(negedge clk); chk("rmf.grantB", 32'(req_ready), 32'h2);
    next_cycle();
    rst = 1'b1; req_valid = 4'b0011;
    @(negedge clk);
    chk("rmf.rst_ready",   32'(req_ready),      32'h0);
    chk("rmf.rst_maddr_v", 32'(mem_addr_valid), 32'h0);
    chk("rmf.rst_resp",    32'(resp_valid),     32'h0);
    next_cycle();
    rst = 1'b0; req_valid = 4'b0000;
    @(negedge clk);
    chk("rmf.post_resp",  32'(resp_valid),  32'h0);
    chk("rmf.post_id",    32'(resp_id),     32'h0);
    chk("rmf.post_busy",  32'(busy),        32'h0);
    chk("rmf.post_count", 32'(issue_count), 32'h0);
    next_cycle();
    @(negedge clk);
    chk("rmf.late_resp",  32'(resp_valid),  32'h0);
    next_cycle();
    req_valid = 4'b1001;
    @(negedge clk);
    chk("rmf.ptr_reset",  32'(req_ready),   32'h1);
    next_cycle();

    // Counter wrap after 65535 back-to-back grants.
    rst = 1'b1; req_valid = 4'b0000;
    next_cycle();
    rst = 1'b0; req_valid = 4'b0001;
    repeat (65535) @(posedge clk);
    #1;
    @(negedge clk);
    chk("wrap.max",   32'(issue_count), 32'hFFFF);
    chk("wrap.ready", 32'(req_ready),   32'h1);
    next_cycle();
    @(negedge clk);
    chk("wrap.zero",  32'(issue_count), 32'h0);
    req_valid = 4'b0000;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
